pipe_ctrl_unit: RTL

//  MIPS pipelined main-control successor: decodes op in ID and carries EX/M/WB control bundles through ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_ctrl_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall with bubble insertion, MEM-stage branch flush and a saturating stall counter.
module pipe_ctrl_unit #(
    parameter int OP_W        = 6,
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_W-1:0]        id_op,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   mem_zero,
    output logic [2+ALUOP_W-1:0]   ex_ctrl,
    output logic [2:0]             mem_ctrl,
    output logic [1:0]             wb_ctrl,
    output logic                   id_jump,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   pc_src,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int EX_W = 2 + ALUOP_W;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    // Decoded ID bundle
    logic [EX_W-1:0] dec_ex;
    logic [2:0]      dec_m;
    logic [1:0]      dec_wb;
    logic            dec_bne;
    logic            dec_uses_rt;

    // Pipeline control registers
    logic [EX_W-1:0] idex_ex_q, idex_ex_d;
    logic [2:0]      idex_m_q, idex_m_d;
    logic [1:0]      idex_wb_q, idex_wb_d;
    logic            idex_bne_q, idex_bne_d;
    logic [2:0]      exmem_m_q, exmem_m_d;
    logic [1:0]      exmem_wb_q, exmem_wb_d;
    logic            exmem_bne_q, exmem_bne_d;
    logic [1:0]      memwb_wb_q, memwb_wb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic flush;
    logic stall;

    always_comb begin
        dec_ex      = '0;
        dec_m       = '0;
        dec_wb      = '0;
        dec_bne     = 1'b0;
        dec_uses_rt = 1'b0;
        if (id_valid) begin
            unique case (id_op)
                OP_R: begin
                    dec_ex      = {1'b1, ALU_FUNCT, 1'b0};
                    dec_wb      = 2'b10;
                    dec_uses_rt = 1'b1;
                end
                OP_LW: begin
                    dec_ex = {1'b0, ALU_ADD, 1'b1};
                    dec_m  = 3'b010;
                    dec_wb = 2'b11;
                end
                OP_SW: begin
                    dec_ex      = {1'b0, ALU_ADD, 1'b1};
                    dec_m       = 3'b001;
                    dec_uses_rt = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    dec_ex      = {1'b0, ALU_SUB, 1'b0};
                    dec_m       = 3'b100;
                    dec_bne     = (id_op == OP_BNE);
                    dec_uses_rt = 1'b1;
                end
                OP_ADDI: begin
                    dec_ex = {1'b0, ALU_ADD, 1'b1};
                    dec_wb = 2'b10;
                end
                default: ;
            endcase
        end
    end

    // Reset gating keeps stale register contents from stalling or redirecting during rst.
    always_comb begin
        pc_src = ~rst & exmem_m_q[2] & (mem_zero ^ exmem_bne_q);
        hazard = ~rst & id_valid & idex_m_q[1] & (ex_rt != '0) &
                 ((ex_rt == id_rs) | ((ex_rt == id_rt) & dec_uses_rt));
        flush  = pc_src;
        stall  = hazard & ~flush;
    end

    always_comb begin
        idex_ex_d   = dec_ex;
        idex_m_d    = dec_m;
        idex_wb_d   = dec_wb;
        idex_bne_d  = dec_bne;
        exmem_m_d   = idex_m_q;
        exmem_wb_d  = idex_wb_q;
        exmem_bne_d = idex_bne_q;
        memwb_wb_d  = exmem_wb_q;
        stall_cnt_d = stall_cnt_q;
        if (flush || stall) begin
            idex_ex_d  = '0;
            idex_m_d   = '0;
            idex_wb_d  = '0;
            idex_bne_d = 1'b0;
        end
        if (flush) begin
            exmem_m_d   = '0;
            exmem_wb_d  = '0;
            exmem_bne_d = 1'b0;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ex_q   <= '0;
            idex_m_q    <= '0;
            idex_wb_q   <= '0;
            idex_bne_q  <= 1'b0;
            exmem_m_q   <= '0;
            exmem_wb_q  <= '0;
            exmem_bne_q <= 1'b0;
            memwb_wb_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_m_q    <= idex_m_d;
            idex_wb_q   <= idex_wb_d;
            idex_bne_q  <= idex_bne_d;
            exmem_m_q   <= exmem_m_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_bne_q <= exmem_bne_d;
            memwb_wb_q  <= memwb_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        ex_ctrl     = idex_ex_q;
        mem_ctrl    = exmem_m_q;
        wb_ctrl     = memwb_wb_q;
        id_jump     = id_valid & (id_op == OP_J) & ~flush;
        pc_write    = ~stall;
        ifid_write  = ~stall;
        ifid_flush  = flush;
        stall_count = stall_cnt_q;
    end

endmodule
